// File: rtl/video_timing_gen.sv
// Free-running 720x576p50 / 720x480p60 raster timing generator.
// Counters start at the first visible pixel. A vreset pulse re-aligns them to the core video.
module video_timing_gen #(
    parameter int unsigned PAL_HACT  = 720,
    parameter int unsigned PAL_HFP   = 12,
    parameter int unsigned PAL_HSW   = 64,
    parameter int unsigned PAL_HBP   = 68,
    parameter int unsigned PAL_VACT  = 576,
    parameter int unsigned PAL_VFP   = 5,
    parameter int unsigned PAL_VSW   = 5,
    parameter int unsigned PAL_VBP   = 39,
    parameter int unsigned NTSC_HACT = 720,
    parameter int unsigned NTSC_HFP  = 16,
    parameter int unsigned NTSC_HSW  = 62,
    parameter int unsigned NTSC_HBP  = 60,
    parameter int unsigned NTSC_VACT = 480,
    parameter int unsigned NTSC_VFP  = 9,
    parameter int unsigned NTSC_VSW  = 6,
    parameter int unsigned NTSC_VBP  = 30,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] mode,
    input  logic       vreset,
    output logic       hs,
    output logic       vs,
    output logic       de,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       frame_start,
    output logic [7:0] resync_cnt
);

    // Window boundaries per timing set: active end, sync start, sync end, last count.
    localparam logic [9:0] PHACT  = 10'(PAL_HACT);
    localparam logic [9:0] PHSS   = 10'(PAL_HACT + PAL_HFP);
    localparam logic [9:0] PHSE   = 10'(PAL_HACT + PAL_HFP + PAL_HSW);
    localparam logic [9:0] PHLAST = 10'(PAL_HACT + PAL_HFP + PAL_HSW + PAL_HBP - 1);
    localparam logic [9:0] PVACT  = 10'(PAL_VACT);
    localparam logic [9:0] PVSS   = 10'(PAL_VACT + PAL_VFP);
    localparam logic [9:0] PVSE   = 10'(PAL_VACT + PAL_VFP + PAL_VSW);
    localparam logic [9:0] PVLAST = 10'(PAL_VACT + PAL_VFP + PAL_VSW + PAL_VBP - 1);
    localparam logic [9:0] NHACT  = 10'(NTSC_HACT);
    localparam logic [9:0] NHSS   = 10'(NTSC_HACT + NTSC_HFP);
    localparam logic [9:0] NHSE   = 10'(NTSC_HACT + NTSC_HFP + NTSC_HSW);
    localparam logic [9:0] NHLAST = 10'(NTSC_HACT + NTSC_HFP + NTSC_HSW + NTSC_HBP - 1);
    localparam logic [9:0] NVACT  = 10'(NTSC_VACT);
    localparam logic [9:0] NVSS   = 10'(NTSC_VACT + NTSC_VFP);
    localparam logic [9:0] NVSE   = 10'(NTSC_VACT + NTSC_VFP + NTSC_VSW);
    localparam logic [9:0] NVLAST = 10'(NTSC_VACT + NTSC_VFP + NTSC_VSW + NTSC_VBP - 1);

    logic [9:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [1:0] cur_mode_q, cur_mode_d;
    logic [7:0] resync_q, resync_d;
    logic       hs_q, hs_d, vs_q, vs_d, de_q, de_d, fs_q, fs_d;
    logic [9:0] x_q, x_d, y_q, y_d;

    logic [9:0] hact, hss, hse, hlast, vact, vss, vse, vlast;
    logic       at_wrap;

    // Select the timing set of the frame in progress; only mode 0 is NTSC.
    always_comb begin
        if (cur_mode_q == 2'd0) begin
            hact = NHACT; hss = NHSS; hse = NHSE; hlast = NHLAST;
            vact = NVACT; vss = NVSS; vse = NVSE; vlast = NVLAST;
        end else begin
            hact = PHACT; hss = PHSS; hse = PHSE; hlast = PHLAST;
            vact = PVACT; vss = PVSS; vse = PVSE; vlast = PVLAST;
        end
    end

    // Counter, timing-select and resync-count next state.
    always_comb begin
        at_wrap    = (hcnt_q == hlast) && (vcnt_q == vlast);
        hcnt_d     = hcnt_q;
        vcnt_d     = vcnt_q;
        cur_mode_d = cur_mode_q;
        resync_d   = resync_q;
        if (vreset) begin
            hcnt_d     = '0;
            vcnt_d     = '0;
            cur_mode_d = mode;
            // Only a resync that actually moved the raster is counted.
            if (!at_wrap && resync_q != 8'hff) begin
                resync_d = resync_q + 8'd1;
            end
        end else if (hcnt_q >= hlast) begin
            hcnt_d = '0;
            if (vcnt_q >= vlast) begin
                vcnt_d     = '0;
                cur_mode_d = mode;
            end else begin
                vcnt_d = vcnt_q + 10'd1;
            end
        end else begin
            hcnt_d = hcnt_q + 10'd1;
            // A line count left beyond the frame total recovers immediately.
            if (vcnt_q > vlast) begin
                vcnt_d = '0;
            end
        end
    end

    // Output decode of the current counters; registered below for a 1-clk lag.
    always_comb begin
        de_d = (hcnt_q < hact) && (vcnt_q < vact);
        hs_d = (hcnt_q >= hss && hcnt_q < hse) ? SYNC_POL : ~SYNC_POL;
        vs_d = (vcnt_q >= vss && vcnt_q < vse) ? SYNC_POL : ~SYNC_POL;
        x_d  = de_d ? hcnt_q : '0;
        y_d  = de_d ? vcnt_q : '0;
        fs_d = (hcnt_q == '0) && (vcnt_q == '0);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hcnt_q     <= '0;
            vcnt_q     <= '0;
            cur_mode_q <= 2'd1;
            resync_q   <= '0;
            hs_q       <= ~SYNC_POL;
            vs_q       <= ~SYNC_POL;
            de_q       <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            fs_q       <= 1'b0;
        end else begin
            hcnt_q     <= hcnt_d;
            vcnt_q     <= vcnt_d;
            cur_mode_q <= cur_mode_d;
            resync_q   <= resync_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            de_q       <= de_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fs_q       <= fs_d;
        end
    end

    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign frame_start = fs_q;
    assign resync_cnt  = resync_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen on a scaled-down raster so whole frames fit in a short run.
module tb_video_timing_gen;

    // PAL-like set: line 25, frame 11 lines. NTSC-like set: line 20, frame 9 lines.
    localparam int PHA = 16, PHF = 2, PHS = 4, PHB = 3;
    localparam int PVA = 6,  PVF = 1, PVS = 2, PVB = 2;
    localparam int NHA = 12, NHF = 3, NHS = 3, NHB = 2;
    localparam int NVA = 5,  NVF = 2, NVS = 1, NVB = 1;
    localparam int PAL_FRAME  = (PHA + PHF + PHS + PHB) * (PVA + PVF + PVS + PVB); // 275
    localparam int NTSC_FRAME = (NHA + NHF + NHS + NHB) * (NVA + NVF + NVS + NVB); // 180

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] mode;
    logic       vreset;
    logic       hs, vs, de, frame_start;
    logic [9:0] x, y;
    logic [7:0] resync_cnt;

    video_timing_gen #(
        .PAL_HACT(PHA), .PAL_HFP(PHF), .PAL_HSW(PHS), .PAL_HBP(PHB),
        .PAL_VACT(PVA), .PAL_VFP(PVF), .PAL_VSW(PVS), .PAL_VBP(PVB),
        .NTSC_HACT(NHA), .NTSC_HFP(NHF), .NTSC_HSW(NHS), .NTSC_HBP(NHB),
        .NTSC_VACT(NVA), .NTSC_VFP(NVF), .NTSC_VSW(NVS), .NTSC_VBP(NVB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk(clk),
        .reset(reset),
        .mode(mode),
        .vreset(vreset),
        .hs(hs),
        .vs(vs),
        .de(de),
        .x(x),
        .y(y),
        .frame_start(frame_start),
        .resync_cnt(resync_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Bench model of the raster position and resync count.
    int mh, mv, mm, mcnt;
    logic [31:0] sb_q[$];
    int cyc = 0, last_fs_cyc = -1, last_period = 0;
    int de_acc = 0, frame_de = 0;

    localparam logic [31:0] RST_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 8'd0};

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {hs, vs, de, x, y, frame_start, resync_cnt};
    endfunction

    function automatic int htot(input int m);
        return (m == 0) ? NHA + NHF + NHS + NHB : PHA + PHF + PHS + PHB;
    endfunction

    function automatic int vtot(input int m);
        return (m == 0) ? NVA + NVF + NVS + NVB : PVA + PVF + PVS + PVB;
    endfunction

    // Expected registered outputs for the current model position (resync field left 0).
    function automatic logic [31:0] expect_pos();
        int ha, hf, hw, va, vf, vw;
        logic e_de, e_hs, e_vs, e_fs;
        logic [9:0] e_x, e_y;
        ha = (mm == 0) ? NHA : PHA; hf = (mm == 0) ? NHF : PHF; hw = (mm == 0) ? NHS : PHS;
        va = (mm == 0) ? NVA : PVA; vf = (mm == 0) ? NVF : PVF; vw = (mm == 0) ? NVS : PVS;
        e_de = (mh < ha) && (mv < va);
        e_hs = !((mh >= ha + hf) && (mh < ha + hf + hw));
        e_vs = !((mv >= va + vf) && (mv < va + vf + vw));
        e_fs = (mh == 0) && (mv == 0);
        e_x  = e_de ? 10'(mh) : 10'd0;
        e_y  = e_de ? 10'(mv) : 10'd0;
        return {e_hs, e_vs, e_de, e_x, e_y, e_fs, 8'd0};
    endfunction

    task automatic model_step(input int m, input logic vr);
        if (vr) begin
            if (!(mh == htot(mm) - 1 && mv == vtot(mm) - 1) && mcnt < 255) mcnt++;
            mh = 0; mv = 0; mm = m;
        end else if (mh == htot(mm) - 1) begin
            mh = 0;
            if (mv == vtot(mm) - 1) begin
                mv = 0; mm = m;
            end else begin
                mv++;
            end
        end else begin
            mh++;
        end
    endtask

    task automatic model_reset();
        mh = 0; mv = 0; mm = 1; mcnt = 0;
        sb_q.delete();
        last_fs_cyc = -1;
        de_acc = 0;
    endtask

    // One clock: drive inputs (called at a negedge), push expectation, compare after the edge.
    task automatic tick(input logic [1:0] m, input logic vr);
        logic [31:0] e;
        mode = m;
        vreset = vr;
        e = expect_pos();
        model_step(int'(m), vr);
        e[7:0] = 8'(mcnt);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        cyc++;
        check("outs", dut_vec(), sb_q.pop_front());
        if (frame_start) begin
            if (last_fs_cyc >= 0) last_period = cyc - last_fs_cyc;
            last_fs_cyc = cyc;
            frame_de = de_acc;
            de_acc = de ? 1 : 0;
        end else if (de) begin
            de_acc++;
        end
        @(negedge clk);
    endtask

    task automatic run_until_fs(input logic [1:0] m, input int budget);
        int n = 0;
        logic got = 1'b0;
        while (!got && n < budget) begin
            tick(m, 1'b0);
            n++;
            if (frame_start) got = 1'b1;
        end
        if (!got) check("fs_timeout", 32'd0, 32'd1);
    endtask

    task automatic advance_to(input logic [1:0] m, input int h, input int v);
        int n = 0;
        while (!(mh == h && mv == v) && n < 1000) begin
            tick(m, 1'b0);
            n++;
        end
        if (!(mh == h && mv == v)) check("advance_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        mode = 2'd1;
        vreset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_vals", dut_vec(), RST_VEC);

        reset = 1'b0;
        model_reset();

        // PAL from reset: frame period and active pixel count.
        run_until_fs(2'd1, 400);
        run_until_fs(2'd1, 400);
        check("pal_period", 32'(last_period), 32'(PAL_FRAME));
        check("pal_de_cnt", 32'(frame_de), 32'(PHA * PVA));

        // Mode 1->0 mid-frame: PAL frame completes, NTSC from the next frame.
        advance_to(2'd1, 0, 3);
        run_until_fs(2'd0, 400);
        check("toggle_pal_period", 32'(last_period), 32'(PAL_FRAME));
        run_until_fs(2'd0, 400);
        check("ntsc_period", 32'(last_period), 32'(NTSC_FRAME));
        check("ntsc_de_cnt", 32'(frame_de), 32'(NHA * NVA));

        // Mode 2 uses PAL timing, taking effect after the NTSC frame in progress.
        run_until_fs(2'd2, 400);
        check("mono_prev_period", 32'(last_period), 32'(NTSC_FRAME));
        run_until_fs(2'd2, 400);
        check("mono_period", 32'(last_period), 32'(PAL_FRAME));

        // Misaligned vreset mid-frame.
        advance_to(2'd1, 10, 3);
        tick(2'd1, 1'b1);
        tick(2'd1, 1'b0);
        check("vreset_first_px", {28'd0, de, x == 10'd0, y == 10'd0, frame_start}, 32'hF);
        check("vreset_cnt1", 32'(resync_cnt), 32'd1);
        run_until_fs(2'd1, 400);
        check("vreset_period", 32'(last_period), 32'(PAL_FRAME));

        // vreset exactly at the natural wrap: raster unchanged, not counted.
        advance_to(2'd1, htot(1) - 1, vtot(1) - 1);
        tick(2'd1, 1'b1);
        tick(2'd1, 1'b0);
        check("wrap_fs", 32'(frame_start), 32'd1);
        check("wrap_period", 32'(last_period), 32'(PAL_FRAME));
        check("wrap_cnt", 32'(resync_cnt), 32'd1);

        // Saturation of the resync counter.
        repeat (300) tick(2'd1, 1'b1);
        tick(2'd1, 1'b0);
        check("resync_sat", 32'(resync_cnt), 32'd255);

        // Asynchronous reset in the middle of an active line.
        advance_to(2'd1, 5, 1);
        check("pre_rst_de", 32'(de), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst", dut_vec(), RST_VEC);
        @(posedge clk);
        #1;
        check("rst_hold", dut_vec(), RST_VEC);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        run_until_fs(2'd1, 400);
        run_until_fs(2'd1, 400);
        check("post_rst_period", 32'(last_period), 32'(PAL_FRAME));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Free-running HDMI-side raster timing generator. Produces hs/vs/de and pixel coordinates for the 720x576p50 (PAL) and 720x480p60 (NTSC) raster.
- Consumes the `vreset` pulse and `mode` from the video analyser. On `vreset` it re-aligns its counters to the first visible pixel, so HDMI output stays locked to the core's video.
- Sits between the analyser and the HDMI encoder/scaler read side, in the pixel clock domain.

Parameters:
- PAL_HACT, 720, PAL active pixels per line
- PAL_HFP, 12, PAL h front porch
- PAL_HSW, 64, PAL hsync width
- PAL_HBP, 68, PAL h back porch (line total 864)
- PAL_VACT, 576, PAL active lines
- PAL_VFP, 5, PAL v front porch
- PAL_VSW, 5, PAL vsync width
- PAL_VBP, 39, PAL v back porch (frame total 625)
- NTSC_HACT, 720, NTSC active pixels per line
- NTSC_HFP, 16, NTSC h front porch
- NTSC_HSW, 62, NTSC hsync width
- NTSC_HBP, 60, NTSC h back porch (line total 858)
- NTSC_VACT, 480, NTSC active lines
- NTSC_VFP, 9, NTSC v front porch
- NTSC_VSW, 6, NTSC vsync width
- NTSC_VBP, 30, NTSC v back porch (frame total 525)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  pixel clock; sole clock
- reset  in  1  asynchronous, active-high reset
- mode  in  2  0=NTSC, 1=PAL, 2=mono, 3=reserved; 2 and 3 use PAL timing
- vreset  in  1  synchronous one-cycle resync request
- hs  out  1  horizontal sync, level per SYNC_POL
- vs  out  1  vertical sync, level per SYNC_POL
- de  out  1  data enable, high in the active area
- x  out  10  active pixel column; 0 outside the active area
- y  out  10  active line; 0 outside the active area
- frame_start  out  1  one-cycle pulse with the first active pixel of a frame
- resync_cnt  out  8  saturating count of vreset events that moved the counters

Behaviour:
- Counter structure:
  - Internal hcnt (10 bit) and vcnt (10 bit). Origin (0,0) is the first active pixel.
  - Horizontal order: active [0,HACT), front porch, sync [HACT+HFP, HACT+HFP+HSW), back porch, wrap at HTOT-1.
  - Vertical order is the same, using line indices.
  - hcnt wraps HTOT-1 -> 0 and increments vcnt. vcnt wraps VTOT-1 -> 0.
- Timing select:
  - Active timing set is a registered copy `cur_mode`.
  - `cur_mode` is loaded from mode only at the frame wrap (hcnt=HTOT-1, vcnt=VTOT-1) or on vreset. It never changes mid-frame.
- Output decode:
  - All outputs are registered, decoded from the current hcnt/vcnt.
  - Outputs lag the counters by exactly 1 clk.
  - x = hcnt and y = vcnt when de=1; otherwise x = y = 0.
  - hs is asserted for hcnt in the sync window on every line.
  - vs is asserted for vcnt in the vsync window, for whole lines. Transitions coincide with hcnt=0.
- vreset:
  - In the cycle after vreset=1: hcnt = vcnt = 0 and `cur_mode` = mode. Outputs show de=1, x=0, y=0, frame_start=1 one cycle later (2 clk after vreset).
  - resync_cnt increments, saturating at 255, only if the counters were not already at (HTOT-1, VTOT-1) when vreset was sampled, i.e. the resync actually moved the raster.
  - vreset coinciding with the natural frame wrap: vreset wins. The result is identical, and it is not counted.
- Out-of-range counters (NTSC->PAL switch done via vreset only): the counter compare uses `>=` on the wrap so no lockup beyond HTOT/VTOT is possible. Any count >= total wraps to 0 on the next clk.
- Reset values, while reset is asserted and until the first clk after release:
  - hcnt=0, vcnt=0, cur_mode=1 (PAL)
  - hs=vs=inactive level (1 when SYNC_POL=0)
  - de=0, x=0, y=0, frame_start=0, resync_cnt=0
  - First clk after release: counters advance from (0,0). Outputs for (0,0) appear one clk later.
- Reset mid-frame: immediate asynchronous clear to the reset values. No partial sync pulse may persist.
- Widths: all compares are unsigned 10 bit; totals (<=864) fit.

Test Plan:
- Reset release, mode=1, run 2 frames:
  - hs period 864 clk, low for 64 clk, starting 732 clk after each de rising edge.
  - de high 720 clk per line on 576 lines/frame.
  - vs low for 5 lines; frame period 540000 clk.
- mode=0 from reset (first frame PAL, then NTSC):
  - Frame after the first wrap has line total 858, 480 active lines, vsync of 6 lines.
  - Frame period 450450 clk.
- Mode toggled 1->0 at line 100 mid-frame:
  - Current frame completes with PAL timing (864x625).
  - Switch takes effect at the next frame start; no short line.
- vreset pulse at hcnt=400, vcnt=200 (PAL):
  - 2 clk later de=1, x=0, y=0, frame_start=1.
  - resync_cnt 0->1; next frame_start follows 540000 clk later.
- vreset at hcnt=863, vcnt=624 (PAL):
  - Raster unchanged, frame_start at the normal time.
  - resync_cnt stays 0.
- 300 misaligned vreset pulses:
  - resync_cnt saturates at 255.
- Async reset asserted mid-active-line:
  - Outputs go to reset values without waiting for clk; hs/vs=1, de=0.
